// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_N = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

  // Start edge, N iteration edges, one sign-fix edge.
  function automatic int unsigned muldiv_lat(input int unsigned n);
    return n + 2;
  endfunction

  localparam int unsigned MULDIV_LAT = muldiv_lat(MULDIV_N);

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/result bundle between the pipeline and the mul/div unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned N = 32
);

  logic            start;
  muldiv_op_t      op;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            hi_we;
  logic            lo_we;
  logic [N-1:0]    wdata;
  logic            busy;
  logic            done;
  logic [N-1:0]    hi;
  logic [N-1:0]    lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] rem,
  input  logic         dbit,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic         qbit
);

  logic [N:0]   shifted;
  logic [N+1:0] trial;
  logic         unused_trial_bit;

  // Carry out of shifted + ~divisor + 1 is set exactly when shifted >= divisor.
  always_comb begin
    shifted  = {rem, dbit};
    trial    = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + (N+2)'(1);
    qbit     = trial[N+1];
    rem_next = qbit ? trial[N-1:0] : shifted[N-1:0];
  end

  // A successful subtraction leaves a value below the divisor, so bit N is always zero.
  assign unused_trial_bit = trial[N];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier is zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned N = MULDIV_N
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(N) + 1;

  muldiv_state_t   state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            neg_res;
  logic            neg_rem;
  logic            div0;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [N-1:0]    a_orig;
  logic [N-1:0]    hi_q;
  logic [N-1:0]    lo_q;
  logic            done_q;

  // Operand decode at request time
  logic            op_signed;
  logic            op_div;
  logic            a_neg;
  logic            b_neg;
  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;

  always_comb begin
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    a_neg     = op_signed & bus.a[N-1];
    b_neg     = op_signed & bus.b[N-1];
    a_mag     = a_neg ? (~bus.a + N'(1)) : bus.a;
    b_mag     = b_neg ? (~bus.b + N'(1)) : bus.b;
  end

  // Divide datapath: remainder in acc high half, dividend/quotient in acc low half
  logic [N-1:0]    rem_next;
  logic            qbit;

  div_step #(.N(N)) u_div_step (
    .rem      (acc[2*N-1:N]),
    .dbit     (acc[N-1]),
    .divisor  (mplier),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // Multiply datapath and loop exit
  logic [N-1:0]    mplier_nx;
  logic [2*N-1:0]  acc_mul;
  logic            last_iter;
  logic            mul_exit;
  logic            run_exit;

  always_comb begin
    mplier_nx = mplier >> 1;
    acc_mul   = acc + (mplier[0] ? mcand : '0);
    last_iter = (cnt == CW'(N - 1));
`ifdef MULDIV_EARLY_OUT_EN
    mul_exit  = last_iter || (mplier_nx == '0);
`else
    mul_exit  = last_iter;
`endif
    run_exit  = is_div ? last_iter : mul_exit;
  end

  // Sign correction and special-case selection applied in FIX
  logic [2*N-1:0]  prod;
  logic [N-1:0]    quot;
  logic [N-1:0]    rem_fix;
  logic [N-1:0]    res_hi;
  logic [N-1:0]    res_lo;

  always_comb begin
    prod    = neg_res ? (~acc + (2*N)'(1)) : acc;
    quot    = neg_res ? (~acc[N-1:0] + N'(1)) : acc[N-1:0];
    rem_fix = neg_rem ? (~acc[2*N-1:N] + N'(1)) : acc[2*N-1:N];
    res_hi  = prod[2*N-1:N];
    res_lo  = prod[N-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi = a_orig;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quot;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      a_orig  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            is_div  <= op_div;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= op_div & a_neg;
            div0    <= op_div && (bus.b == '0);
            a_orig  <= bus.a;
            mplier  <= b_mag;
            mcand   <= {{N{1'b0}}, a_mag};
            acc     <= op_div ? {{N{1'b0}}, a_mag} : '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            acc <= {rem_next, acc[N-2:0], qbit};
          end else begin
            acc    <= acc_mul;
            mcand  <= mcand << 1;
            mplier <= mplier_nx;
          end
          if (run_exit) state <= FIX;
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic reset;

  muldiv_if #(.N(N)) bus ();

  muldiv_unit #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00:   r = 64'(sa * sb);
      2'b01:   r = 64'(a) * 64'(b);
      default: begin
        if (b == 32'd0)      r = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) r = {32'(sa % sb), 32'(sa / sb)};
        else                 r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Cycles from the start-presenting cycle through the done cycle.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    int bits;
    m = (op == 2'b00 && b[31]) ? (~b + 32'd1) : b;
    bits = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
    if (bits < 1) bits = 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (op[1] == 1'b0) return 2 + bits;
`endif
    return int'(N) + 2 + (bits - bits);
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mthi, input logic [31:0] mdata, input int poke_edge);
    logic [63:0] exp;
    int lat;
    int edges;
    int busy_cnt;
    int guard;
    logic hold_ok;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " idle_before"}, 64'(bus.busy), 64'(0));
    exp = ref_result(op, a, b);
    lat = exp_lat(op, b);
    bus.op    = muldiv_op_t'(op);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    bus.hi_we = mthi;
    bus.wdata = mdata;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    if (mthi) m_hi = mdata;
    edges = 0;
    busy_cnt = 0;
    hold_ok = 1'b1;
    while (bus.done !== 1'b1 && edges < 200) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
      if (edges == poke_edge) begin
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    check({tag, " done_edge"}, 64'(edges), 64'(lat - 1));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
    check({tag, " hold_hilo"}, 64'(hold_ok), 64'(1));
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
    check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_w;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    m_hi = '0;
    m_lo = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset hi", 64'(bus.hi), 64'(0));
    check("reset lo", 64'(bus.lo), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // MTHI / MTLO while idle
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; m_hi = 32'h0000_1234;
    check("mthi idle", 64'(bus.hi), 64'(32'h0000_1234));
    bus.lo_we = 1'b1; bus.wdata = 32'h0000_0055;
    @(posedge clk); #1;
    bus.lo_we = 1'b0; m_lo = 32'h0000_0055;
    check("mtlo idle", 64'(bus.lo), 64'(32'h0000_0055));

    run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, -1);
    check("multu_ff hi const", 64'(bus.hi), 64'(32'hFFFF_FFFE));
    check("multu_ff lo const", 64'(bus.lo), 64'(32'h0000_0001));

    run_op("mult_m7x3", 2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0, 32'd0, -1);
    check("mult_m7x3 hi const", 64'(bus.hi), 64'(32'hFFFF_FFFF));
    check("mult_m7x3 lo const", 64'(bus.lo), 64'(32'hFFFF_FFEB));

    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, -1);
    check("div_m7d2 hi const", 64'(bus.hi), 64'(32'hFFFF_FFFF));
    check("div_m7d2 lo const", 64'(bus.lo), 64'(32'hFFFF_FFFD));

    run_op("divu_100d0", 2'b11, 32'd100, 32'd0, 1'b0, 32'd0, -1);
    check("divu_100d0 hi const", 64'(bus.hi), 64'(32'd100));
    check("divu_100d0 lo const", 64'(bus.lo), 64'(32'hFFFF_FFFF));

    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, -1);
    check("div_ovf hi const", 64'(bus.hi), 64'(32'd0));
    check("div_ovf lo const", 64'(bus.lo), 64'(32'h8000_0000));

    run_op("div_m5d0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'd0, -1);
    check("div_m5d0 hi const", 64'(bus.hi), 64'(32'hFFFF_FFFB));

    // MTHI while idle, then a divide with start+MTHI poked mid-flight
    @(posedge clk); #1;
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; m_hi = 32'h0000_1234;
    check("mthi before div", 64'(bus.hi), 64'(32'h0000_1234));
    run_op("div_17d5_poke", 2'b10, 32'd17, 32'd5, 1'b0, 32'd0, 5);
    check("div_17d5 hi const", 64'(bus.hi), 64'(32'd2));
    check("div_17d5 lo const", 64'(bus.lo), 64'(32'd3));
    @(posedge clk); #1;
    check("poked start ignored", 64'(bus.busy), 64'(0));

    // Asynchronous reset in the middle of a DIVU
    bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst busy", 64'(bus.busy), 64'(0));
    check("midrst done", 64'(bus.done), 64'(0));
    check("midrst hi", 64'(bus.hi), 64'(0));
    check("midrst lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #1;
    check("post reset idle", 64'(bus.busy), 64'(0));

    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 1'b0, 32'd0, -1);
    check("multu_6x7 lo const", 64'(bus.lo), 64'(32'd42));

    run_op("multu_5x3", 2'b01, 32'd5, 32'd3, 1'b0, 32'd0, -1);
    check("multu_5x3 lo const", 64'(bus.lo), 64'(32'd15));

    // MTHI in the same cycle as start is overwritten at FIX
    run_op("mult_with_mthi", 2'b00, 32'h0001_0000, 32'hFFFF_0000, 1'b1, 32'hCAFE_F00D, -1);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r_w = $urandom;
        bus.lo_we = 1'b1; bus.wdata = r_w;
        @(posedge clk); #1;
        bus.lo_we = 1'b0; m_lo = r_w;
        check("rand mtlo", 64'(bus.lo), 64'(r_w));
      end
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(0, 15));
        2:       r_b = 32'hFFFF_FFFF;
        3:       begin r_a = 32'h8000_0000; r_b = $urandom; end
        default: r_b = $urandom;
      endcase
      r_w = $urandom;
      run_op("rand", r_op, r_a, r_b, 1'($urandom_range(0, 3) == 0), r_w, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
